multicycle_control: RTL and testbench

//  Moore FSM control unit for the multi-cycle MIPS datapath. Successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences each opcode through
// fetch/decode/execute/memory/writeback, handles memory-ready waits, timeouts and retire counting.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned WAIT_WIDTH  = 5,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned ENABLE_JUMP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OP,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 BranchEQ,
  output logic                 BranchNE,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSource,
  output logic [2:0]           ALUOp,
  output logic                 IllegalOp,
  output logic                 BusError,
  output logic [CNT_WIDTH-1:0] RetiredCount
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] EXEC_R   = 4'd3;
  localparam logic [3:0] WB_R     = 4'd4;
  localparam logic [3:0] EXEC_I   = 4'd5;
  localparam logic [3:0] WB_I     = 4'd6;
  localparam logic [3:0] MEM_ADDR = 4'd7;
  localparam logic [3:0] MEM_RD   = 4'd8;
  localparam logic [3:0] MEM_WR   = 4'd9;
  localparam logic [3:0] MEM_WB   = 4'd10;
  localparam logic [3:0] BRANCH   = 4'd11;
  localparam logic [3:0] JUMP     = 4'd12;
  localparam logic [3:0] ERROR    = 4'd13;

  localparam logic [5:0] opR    = 6'h00;
  localparam logic [5:0] opJ    = 6'h02;
  localparam logic [5:0] opBeq  = 6'h04;
  localparam logic [5:0] opBne  = 6'h05;
  localparam logic [5:0] opAddi = 6'h08;
  localparam logic [5:0] opOri  = 6'h0d;
  localparam logic [5:0] opLui  = 6'h0f;
  localparam logic [5:0] opLw   = 6'h23;
  localparam logic [5:0] opSw   = 6'h2b;

  localparam logic [2:0] aluAdd = 3'b100;
  localparam logic [2:0] aluOr  = 3'b101;
  localparam logic [2:0] aluLui = 3'b011;
  localparam logic [2:0] aluSub = 3'b001;
  localparam logic [2:0] aluR   = 3'b111;

  localparam logic [WAIT_WIDTH-1:0] waitLast = WAIT_WIDTH'(MEM_TIMEOUT - 1);

  logic [3:0]            state, nextState;
  logic [WAIT_WIDTH-1:0] waitCnt;
  logic                  memWait, timeout, retire;

  // State, wait counter and retire counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      waitCnt      <= '0;
      RetiredCount <= '0;
    end else begin
      state <= nextState;
      if (nextState != state)
        waitCnt <= '0;
      else if (memWait && !MemReady)
        waitCnt <= waitCnt + WAIT_WIDTH'(1);
      if (retire)
        RetiredCount <= RetiredCount + CNT_WIDTH'(1);
    end
  end

  // Next state, timeout and retire detection
  always_comb begin
    nextState = state;
    memWait   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    timeout   = memWait && !MemReady && (waitCnt == waitLast);
    case (state)
      IDLE:     nextState = FETCH;
      FETCH:    if (MemReady) nextState = DECODE;
      DECODE: begin
        case (OP)
          opR:                   nextState = EXEC_R;
          opAddi, opOri, opLui:  nextState = EXEC_I;
          opLw, opSw:            nextState = MEM_ADDR;
          opBeq, opBne:          nextState = BRANCH;
          opJ:                   nextState = (ENABLE_JUMP != 0) ? JUMP : FETCH;
          default:               nextState = FETCH;
        endcase
      end
      EXEC_R:   nextState = WB_R;
      EXEC_I:   nextState = WB_I;
      MEM_ADDR: nextState = (OP == opLw) ? MEM_RD : MEM_WR;
      MEM_RD:   if (MemReady) nextState = MEM_WB;
      MEM_WR:   if (MemReady) nextState = FETCH;
      WB_R, WB_I, MEM_WB, BRANCH, JUMP: nextState = FETCH;
      ERROR:    nextState = ERROR;
      default:  nextState = IDLE;
    endcase
    if (timeout)
      nextState = ERROR;
    retire = (nextState == FETCH) &&
             ((state == WB_R) || (state == WB_I) || (state == MEM_WB) ||
              (state == MEM_WR) || (state == BRANCH) || (state == JUMP));
  end

  // Datapath controls decoded from state (IRWrite/PCWrite follow MemReady in FETCH)
  always_comb begin
    PCWrite   = 1'b0;
    BranchEQ  = 1'b0;
    BranchNE  = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSource  = 2'b00;
    ALUOp     = 3'b000;
    IllegalOp = 1'b0;
    BusError  = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = aluAdd;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        ALUOp     = aluAdd;
        IllegalOp = (nextState == FETCH);
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = aluR;
      end
      WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OP)
          opOri:   ALUOp = aluOr;
          opLui:   ALUOp = aluLui;
          default: ALUOp = aluAdd;
        endcase
      end
      WB_I:     RegWrite = 1'b1;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = aluAdd;
      end
      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = aluSub;
        PCSource = 2'b01;
        BranchEQ = (OP == opBeq);
        BranchNE = (OP == opBne);
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ERROR:   BusError = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory waits,
// timeout, illegal opcodes, reset abort and retire-counter wrap against hand-built control words.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemReady;
  logic [5:0] OP;

  logic       PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalOp, BusError;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [1:0] RetiredCount;

  logic        pcw2, beq2, bne2, iord2, mr2, mw2, irw2, rd2, m2r2, rw2, asa2, ill2, be2;
  logic [1:0]  asb2, pcs2;
  logic [2:0]  alu2;
  logic [31:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4), .WAIT_WIDTH(5), .CNT_WIDTH(2), .ENABLE_JUMP(1)) u (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .IllegalOp(IllegalOp), .BusError(BusError),
    .RetiredCount(RetiredCount)
  );

  // Jump-disabled variant shares the stimulus; only checked while it tracks the main instance
  multicycle_control #(.ENABLE_JUMP(0)) u2 (
    .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
    .PCWrite(pcw2), .BranchEQ(beq2), .BranchNE(bne2), .IorD(iord2),
    .MemRead(mr2), .MemWrite(mw2), .IRWrite(irw2), .RegDst(rd2),
    .MemtoReg(m2r2), .RegWrite(rw2), .ALUSrcA(asa2), .ALUSrcB(asb2),
    .PCSource(pcs2), .ALUOp(alu2), .IllegalOp(ill2), .BusError(be2),
    .RetiredCount(cnt2)
  );

  logic [19:0] ctl;
  assign ctl = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, BusError};

  function automatic logic [19:0] mk(input logic pcw, input logic beq, input logic bne,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic irw, input logic rd, input logic m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] alu,
                                     input logic ill, input logic be);
    return {pcw, beq, bne, iord, mr, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, ill, be};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [19:0] e, input logic [1:0] c);
    chk({tag, ".ctl"}, 32'(ctl), 32'(e));
    chk({tag, ".cnt"}, 32'(RetiredCount), 32'(c));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [19:0] eIdle, eF1, eF0, eDec, eDecIll, eExR, eWbR, eExOri, eWbI, eMa, eMrd, eMwb,
               eMwr, eBne, eJ, eErr;
  logic [1:0]  c;

  initial begin
    eIdle   = '0;
    eF1     = mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,0);
    eF0     = mk(0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b100,0,0);
    eDec    = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,0,0);
    eDecIll = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,1,0);
    eExR    = mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,0);
    eWbR    = mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0);
    eExOri  = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b101,0,0);
    eWbI    = mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0);
    eMa     = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,0);
    eMrd    = mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    eMwb    = mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0);
    eMwr    = mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,0);
    eBne    = mk(0,0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001,0,0);
    eJ      = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0);
    eErr    = mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1);

    reset = 1'b0; MemReady = 1'b1; OP = 6'h00;
    tick; tick;
    look("idle", eIdle, 2'd0);
    reset = 1'b1;

    // R-type, MemReady tied high
    tick; look("r.fetch", eF1, 2'd0);
    tick; look("r.dec", eDec, 2'd0);
    tick; look("r.exec", eExR, 2'd0);
    tick; look("r.wb", eWbR, 2'd0);
    tick; look("r.ret", eF1, 2'd1);

    // LW with three not-ready cycles; ready lands on the last allowed wait
    OP = 6'h23;
    tick; look("lw.dec", eDec, 2'd1);
    tick; look("lw.addr", eMa, 2'd1);
    MemReady = 1'b0;
    tick; look("lw.rd0", eMrd, 2'd1);
    tick; look("lw.rd1", eMrd, 2'd1);
    tick; look("lw.rd2", eMrd, 2'd1);
    tick; MemReady = 1'b1; #1; look("lw.rd3", eMrd, 2'd1);
    tick; look("lw.wb", eMwb, 2'd1);
    tick; look("lw.ret", eF1, 2'd2);

    // BNE
    OP = 6'h05;
    tick; look("bne.dec", eDec, 2'd2);
    tick; look("bne.br", eBne, 2'd2);
    tick; look("bne.ret", eF1, 2'd3);

    // Illegal opcode: pulse in DECODE, not retired
    OP = 6'h3f;
    tick; look("ill.dec", eDecIll, 2'd3);
    tick; look("ill.fetch", eF1, 2'd3);

    // ORI retires and wraps the 2-bit counter
    OP = 6'h0d;
    tick; look("ori.dec", eDec, 2'd3);
    tick; look("ori.exec", eExOri, 2'd3);
    tick; look("ori.wb", eWbI, 2'd3);
    tick; look("ori.ret", eF1, 2'd0);

    // SW
    OP = 6'h2b;
    tick; look("sw.dec", eDec, 2'd0);
    tick; look("sw.addr", eMa, 2'd0);
    tick; look("sw.wr", eMwr, 2'd0);
    tick; look("sw.ret", eF1, 2'd1);

    // Four jumps: 1->2->3->0->1
    OP = 6'h02;
    c = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick; look("j.dec", eDec, c);
      if (i == 0) chk("nojump.ill", 32'(ill2), 32'd1);
      tick; look("j.jump", eJ, c);
      c = c + 2'd1;
      tick; look("j.ret", eF1, c);
    end

    // Fetch timeout: four not-ready cycles then ERROR
    MemReady = 1'b0; #1;
    look("to.f0", eF0, 2'd1);
    tick; look("to.f1", eF0, 2'd1);
    tick; look("to.f2", eF0, 2'd1);
    tick; look("to.f3", eF0, 2'd1);
    tick; look("to.err", eErr, 2'd1);
    MemReady = 1'b1;
    tick; look("to.hold", eErr, 2'd1);

    // Reset recovers; ready on the fourth fetch cycle beats the timeout
    reset = 1'b0;
    tick; look("rst.idle", eIdle, 2'd0);
    reset = 1'b1; MemReady = 1'b0;
    tick; look("win.f0", eF0, 2'd0);
    tick; tick; tick;
    MemReady = 1'b1; #1;
    look("win.f3", eF1, 2'd0);
    tick; look("win.dec", eDec, 2'd0);
    tick; look("win.jump", eJ, 2'd0);
    tick; look("win.ret", eF1, 2'd1);

    // Reset during MEM_WR aborts the store and clears the counter
    OP = 6'h2b;
    tick; look("ab.dec", eDec, 2'd1);
    tick; look("ab.addr", eMa, 2'd1);
    MemReady = 1'b0;
    tick; look("ab.wr", eMwr, 2'd1);
    reset = 1'b0;
    tick; look("ab.idle", eIdle, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
